// File: rtl/fifo_word_packer.sv
// Read-side FIFO agent: drains bytes, packs them little-endian into 32-bit words
// and hands them downstream on valid/ready; FLUSH forces out a partial word.
module fifo_word_packer #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic             SYSCLK,
  input  logic             RST,
  input  logic             EMPTY,
  input  logic [7:0]       FIFO_OUT,
  output logic             RD_EN,
  input  logic             FLUSH,
  output logic [31:0]      WORD_OUT,
  output logic [3:0]       WORD_BE,
  output logic             WORD_VLD,
  input  logic             WORD_RDY,
  output logic             FLUSH_DONE,
  output logic [CNT_W-1:0] BYTE_CNT
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;
  localparam logic [2:0] FULL     = 3'(LANES);

  logic [0:0]       state_r;
  logic [31:0]      acc_r;
  logic [2:0]       fill_r;
  logic             pend_r;
  logic [31:0]      word_out_r;
  logic [3:0]       word_be_r;
  logic             word_vld_r;
  logic             flush_done_r;
  logic [CNT_W-1:0] byte_cnt_r;

  logic             ofree_s;
  logic             xfer_s;
  logic             drain_go_s;
  logic             emit_s;
  logic             rd_en_s;
  logic [3:0]       fill_sum_s;
  logic [2:0]       fill_base_s;
  logic [2:0]       fill_nxt_s;
  logic [31:0]      acc_nxt_s;

  function automatic logic [3:0] be_from_fill(input logic [2:0] fill);
    logic [3:0] be;
    case (fill)
      3'd0:    be = 4'h0;
      3'd1:    be = 4'h1;
      3'd2:    be = 4'h3;
      3'd3:    be = 4'h7;
      3'd4:    be = 4'hF;
      default: be = 4'h0;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] mask;
    mask = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

  // Handshake, read-strobe and word-emission decisions
  always_comb begin
    ofree_s    = !word_vld_r || WORD_RDY;
    xfer_s     = (fill_r == FULL) && ofree_s;
    fill_sum_s = {1'b0, fill_r} + {3'b000, pend_r};
    drain_go_s = (state_r == ST_DRAIN) && !pend_r && ((fill_r == 3'd0) || ofree_s);
    emit_s     = xfer_s || (drain_go_s && (fill_r != 3'd0));
    rd_en_s    = !RST && !EMPTY && (state_r == ST_RUN) && !FLUSH &&
                 ((fill_sum_s < 4'(LANES)) || xfer_s);
  end

  // Accumulator next state: an emitted word frees the lanes before any landing byte
  always_comb begin
    fill_base_s = emit_s ? 3'd0 : fill_r;
    acc_nxt_s   = emit_s ? 32'h0000_0000 : acc_r;
    if (pend_r) begin
      acc_nxt_s[{fill_base_s[1:0], 3'b000} +: 8] = FIFO_OUT;
      fill_nxt_s = fill_base_s + 3'd1;
    end else begin
      fill_nxt_s = fill_base_s;
    end
  end

  // Accumulator, read tracking and byte counter
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      acc_r      <= 32'h0000_0000;
      fill_r     <= 3'd0;
      pend_r     <= 1'b0;
      byte_cnt_r <= {CNT_W{1'b0}};
    end else begin
      acc_r  <= acc_nxt_s;
      fill_r <= fill_nxt_s;
      pend_r <= rd_en_s;
      if (pend_r) begin
        byte_cnt_r <= byte_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Output word register and flush sequencing
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      word_out_r   <= 32'h0000_0000;
      word_be_r    <= 4'h0;
      word_vld_r   <= 1'b0;
      flush_done_r <= 1'b0;
      state_r      <= ST_RUN;
    end else begin
      if (emit_s) begin
        word_out_r <= acc_r & lane_mask(be_from_fill(fill_r));
        word_be_r  <= be_from_fill(fill_r);
        word_vld_r <= 1'b1;
      end else if (WORD_RDY) begin
        word_vld_r <= 1'b0;
      end
      flush_done_r <= drain_go_s;
      case (state_r)
        ST_RUN:   if (FLUSH) state_r <= ST_DRAIN;
        ST_DRAIN: if (drain_go_s) state_r <= ST_RUN;
        default:  state_r <= ST_RUN;
      endcase
    end
  end

  assign RD_EN      = rd_en_s;
  assign WORD_OUT   = word_out_r;
  assign WORD_BE    = word_be_r;
  assign WORD_VLD   = word_vld_r;
  assign FLUSH_DONE = flush_done_r;
  assign BYTE_CNT   = byte_cnt_r;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: a byte-queue FIFO, a word scoreboard built from
// the bytes actually read, directed scenarios and a randomized soak.
module tb_fifo_word_packer;
  localparam int CNT_W = 8;

  logic             sysclk;
  logic             rst, empty, flush, word_rdy;
  logic [7:0]       fifo_out;
  logic             rd_en, word_vld, flush_done;
  logic [31:0]      word_out;
  logic [3:0]       word_be;
  logic [CNT_W-1:0] byte_cnt;

  fifo_word_packer #(.LANES(4), .CNT_W(CNT_W)) dut (
    .SYSCLK(sysclk), .RST(rst), .EMPTY(empty), .FIFO_OUT(fifo_out), .RD_EN(rd_en),
    .FLUSH(flush), .WORD_OUT(word_out), .WORD_BE(word_be), .WORD_VLD(word_vld),
    .WORD_RDY(word_rdy), .FLUSH_DONE(flush_done), .BYTE_CNT(byte_cnt)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic [7:0]  q[$];
  logic [7:0]  cur[$];
  logic [31:0] exp_words[$];
  logic [3:0]  exp_bes[$];
  int          rd_edges[$];
  int n_assert = 0, n_fail = 0, cyc = 0;
  int rd_count = 0, xfer_count = 0, done_count = 0, exp_done = 0, landed = 0;
  int first_rd_edge = -1, first_vld_edge = -1, last_xfer_vis = 0, done_edge = 0;
  bit pend_m = 1'b0, flush_busy = 1'b0, prev_hold = 1'b0, wrap_seen = 1'b0;
  logic [31:0] prev_word = 32'h0, last_word = 32'h0;
  logic [3:0]  prev_be = 4'h0, last_be = 4'h0;
  logic [CNT_W-1:0] prev_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cur();
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < cur.size(); i++) w[8*i +: 8] = cur[i];
    exp_words.push_back(w);
    exp_bes.push_back(4'((1 << cur.size()) - 1));
    cur.delete();
  endtask

  // One clock: inputs already set at edge+1; sample just before the edge, update after it.
  task automatic cycle();
    logic rd, vld, rdy, fl;
    logic [31:0] w;
    logic [3:0] be;
    empty = (q.size() == 0);
    #7;
    rd = rd_en; vld = word_vld; rdy = word_rdy; fl = flush; w = word_out; be = word_be;
    if (rst) begin
      chk("rd_en_in_reset", rd, 1'b0);
    end else begin
      chk("rd_while_empty", rd & empty, 1'b0);
      chk("rd_during_flush", rd & (fl | flush_busy), 1'b0);
      if (prev_hold) begin
        chk("hold_vld", vld, 1'b1);
        chk("hold_word", w, prev_word);
        chk("hold_be", be, prev_be);
      end
      if (vld && rdy) begin
        chk("xfer_expected", exp_words.size() != 0, 1'b1);
        if (exp_words.size() != 0) begin
          chk("xfer_word", w, exp_words.pop_front());
          chk("xfer_be", be, exp_bes.pop_front());
        end
        last_word = w; last_be = be; xfer_count++; last_xfer_vis = cyc;
      end
      prev_hold = vld && !rdy; prev_word = w; prev_be = be;
      if (rd) begin
        rd_count++;
        rd_edges.push_back(cyc + 1);
        if (first_rd_edge < 0) first_rd_edge = cyc + 1;
      end
      if (fl && !flush_busy) begin
        flush_busy = 1'b1;
        exp_done++;
        if (cur.size() > 0) push_cur();
      end
    end
    @(posedge sysclk);
    #1;
    cyc++;
    if (rst) begin
      cur.delete(); exp_words.delete(); exp_bes.delete();
      flush_busy = 1'b0; prev_hold = 1'b0; pend_m = 1'b0; landed = 0; prev_cnt = '0;
    end else begin
      if (pend_m) landed++;
      pend_m = rd;
      chk("byte_cnt", byte_cnt, landed % (1 << CNT_W));
      if (byte_cnt < prev_cnt) wrap_seen = 1'b1;
      prev_cnt = byte_cnt;
      if (rd) begin
        fifo_out = q.pop_front();
        cur.push_back(fifo_out);
        if (cur.size() == 4) push_cur();
      end
      if (flush_done) begin
        chk("done_when_flushing", flush_busy, 1'b1);
        done_count++; done_edge = cyc; flush_busy = 1'b0;
      end
      if (word_vld && first_vld_edge < 0) first_vld_edge = cyc;
    end
  endtask

  initial begin
    int base_rd, base_x, base_d, f_edge, n;
    rst = 1'b1; empty = 1'b1; flush = 1'b0; word_rdy = 1'b1; fifo_out = 8'h00;
    q.push_back(8'h5A);
    @(posedge sysclk);
    #1;

    // Reset held three cycles with data available
    for (int i = 0; i < 3; i++) cycle();
    chk("rst_vld", word_vld, 1'b0);
    chk("rst_word", word_out, 32'h0);
    chk("rst_be", word_be, 4'h0);
    chk("rst_done", flush_done, 1'b0);
    chk("rst_cnt", byte_cnt, '0);
    q.delete();
    rst = 1'b0;
    cycle();
    chk("rel_vld", word_vld, 1'b0);
    chk("rel_word", word_out, 32'h0);
    chk("rel_cnt", byte_cnt, '0);
    chk("rel_rd_en", rd_en, 1'b0);

    // Single word
    first_rd_edge = -1; first_vld_edge = -1; base_x = xfer_count;
    q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33); q.push_back(8'h44);
    repeat (10) cycle();
    chk("single_count", xfer_count - base_x, 1);
    chk("single_word", last_word, 32'h44332211);
    chk("single_be", last_be, 4'hF);
    chk("single_cnt", byte_cnt, 4);
    chk("single_latency", first_vld_edge - first_rd_edge, 5);

    // Backpressure: only 8 bytes absorbed, held word stable
    word_rdy = 1'b0; base_rd = rd_count;
    for (int i = 1; i <= 12; i++) q.push_back(8'(i));
    repeat (20) cycle();
    chk("bp_reads", rd_count - base_rd, 8);
    chk("bp_vld", word_vld, 1'b1);
    chk("bp_head", word_out, 32'h04030201);
    chk("bp_stalled", rd_en, 1'b0);
    word_rdy = 1'b1; base_x = xfer_count;
    repeat (20) cycle();
    chk("bp_words", xfer_count - base_x, 3);
    chk("bp_last", last_word, 32'h0C0B0A09);
    chk("bp_cnt", byte_cnt, 16);

    // Partial flush after the third read
    base_rd = rd_count; base_d = done_count;
    q.push_back(8'hA1); q.push_back(8'hA2); q.push_back(8'hA3);
    for (int i = 0; i < 10 && (rd_count - base_rd) < 3; i++) cycle();
    chk("pf_reads", rd_count - base_rd, 3);
    flush = 1'b1; f_edge = cyc + 1;
    cycle();
    flush = 1'b0;
    repeat (6) cycle();
    chk("pf_word", last_word, 32'h00A3A2A1);
    chk("pf_be", last_be, 4'h7);
    chk("pf_done_once", done_count - base_d, 1);
    chk("pf_latency", (done_edge - f_edge) <= 2, 1'b1);

    // Flush with an empty accumulator
    base_d = done_count; base_x = xfer_count;
    flush = 1'b1; f_edge = cyc + 1;
    cycle();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("fe_vld", word_vld, 1'b0);
    end
    chk("fe_done", done_count - base_d, 1);
    chk("fe_latency", (done_edge - f_edge) <= 2, 1'b1);
    chk("fe_no_word", xfer_count - base_x, 0);

    // Sustained stream, FLUSH coincident with EMPTY falling
    base_rd = rd_count; base_x = xfer_count; first_rd_edge = -1; rd_edges.delete();
    for (int i = 0; i < 16; i++) q.push_back(8'(i));
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("ss_rd_in_flush", rd_count - base_rd, 0);
    repeat (30) cycle();
    chk("ss_words", xfer_count - base_x, 4);
    chk("ss_last", last_word, 32'h0F0E0D0C);
    chk("ss_window", (last_xfer_vis - first_rd_edge) <= 21, 1'b1);
    n = 0;
    foreach (rd_edges[i]) if (rd_edges[i] < first_rd_edge + 20) n++;
    chk("ss_duty", n, 16);

    // Reset mid-operation discards everything, no FLUSH_DONE
    word_rdy = 1'b0;
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    repeat (8) cycle();
    base_d = done_count;
    rst = 1'b1;
    cycle();
    rst = 1'b0; q.delete();
    chk("mid_rst_vld", word_vld, 1'b0);
    chk("mid_rst_word", word_out, 32'h0);
    chk("mid_rst_be", word_be, 4'h0);
    chk("mid_rst_cnt", byte_cnt, '0);
    chk("mid_rst_done", flush_done, 1'b0);
    word_rdy = 1'b1;
    repeat (4) cycle();
    chk("mid_rst_no_done", done_count - base_d, 0);

    // Randomized soak against the scoreboard
    repeat (900) begin
      if (q.size() < 8 && $urandom_range(0, 9) < 8) q.push_back(8'($urandom));
      word_rdy = ($urandom_range(0, 3) != 0);
      flush = !flush_busy && ($urandom_range(0, 24) == 0);
      cycle();
    end
    flush = 1'b0; word_rdy = 1'b1;
    repeat (20) cycle();
    for (int i = 0; i < 20 && flush_busy; i++) cycle();
    chk("final_flush_idle", flush_busy, 1'b0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    for (int i = 0; i < 10 && flush_busy; i++) cycle();
    repeat (4) cycle();
    chk("final_words_left", exp_words.size(), 0);
    chk("final_done", done_count, exp_done);
    chk("cnt_wrapped", wrap_seen, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
